// File: rtl/hangman_display_ctrl_if.sv
// Guess/load handshake bundle for hangman_display_ctrl.
//   load        : one-cycle pulse, captures word_in and starts a new game
//   word_in     : four 5-bit letter codes, slot0 = [4:0] .. slot3 = [19:15]
//   guess_valid : guess_code is valid this cycle
//   guess_code  : letter code of the guess
//   guess_ready : controller accepts a guess this cycle
// master = game driver, slave = display controller.
interface hangman_display_ctrl_if;
  logic        load;
  logic [19:0] word_in;
  logic        guess_valid;
  logic [4:0]  guess_code;
  logic        guess_ready;

  modport master (output load, word_in, guess_valid, guess_code, input guess_ready);
  modport slave  (input load, word_in, guess_valid, guess_code, output guess_ready);
endinterface

// File: rtl/hangman_display_ctrl.sv
// Hangman game controller with a time-multiplexed 4-slot letter display.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   bus           : load/word_in and guess handshake (slave side)
//   dec_enter     : letter code of the selected slot for the shared decoder
//   dec_show      : 1 = show letter, 0 = show blank pattern
//   digit_sel     : one-hot active display slot
//   miss_count    : wrong guesses in the current game
//   hit           : one-cycle pulse after a guess matching any slot
//   win, lose     : game result, held until the next load or reset
module hangman_display_ctrl #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned MAX_MISS = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  hangman_display_ctrl_if.slave bus,
  output logic [4:0]            dec_enter,
  output logic                  dec_show,
  output logic [3:0]            digit_sel,
  output logic [2:0]            miss_count,
  output logic                  hit,
  output logic                  win,
  output logic                  lose
);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_t;

  localparam logic [2:0] MAX_M    = 3'(MAX_MISS);
  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  state_t      state, state_nxt;
  logic [19:0] word;
  logic [3:0]  mask;
  logic [4:0]  guess_q;
  logic [7:0]  div;
  logic [1:0]  slot;
  logic [3:0]  match;
  logic [3:0]  mask_upd;
  logic [2:0]  miss_upd;
  logic        accept;

  // Compare against the registered guess, so guess_code never reaches an output.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < 4; i++)
      match[i] = (word[i*5 +: 5] == guess_q);
    mask_upd = mask | match;
    if (|match || miss_count == MAX_M)
      miss_upd = miss_count;
    else
      miss_upd = miss_count + 3'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.guess_ready = (state == PLAY) && !bus.load;
    accept          = bus.guess_valid && bus.guess_ready;
    if (bus.load) begin
      state_nxt = PLAY;
    end else begin
      unique case (state)
        PLAY:    if (accept) state_nxt = CHECK;
        CHECK: begin
          if (mask_upd == '1 || miss_upd == MAX_M) state_nxt = DONE;
          else                                     state_nxt = PLAY;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      word       <= '0;
      mask       <= '0;
      guess_q    <= '0;
      miss_count <= '0;
      hit        <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (bus.load) begin
        word       <= bus.word_in;
        mask       <= '0;
        miss_count <= '0;
        win        <= 1'b0;
        lose       <= 1'b0;
      end else begin
        if (accept) guess_q <= bus.guess_code;
        if (state == CHECK) begin
          mask       <= mask_upd;
          miss_count <= miss_upd;
          hit        <= |match;
          if (mask_upd == '1)        win  <= 1'b1;
          else if (miss_upd == MAX_M) lose <= 1'b1;
        end
      end
    end
  end

  // Free-running scan, independent of game state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div  <= '0;
      slot <= '0;
    end else if (div == DIV_LAST) begin
      div  <= '0;
      slot <= slot + 2'd1;
    end else begin
      div <= div + 8'd1;
    end
  end

  always_comb begin
    digit_sel = 4'b0001 << slot;
    unique case (slot)
      2'd0:    dec_enter = word[4:0];
      2'd1:    dec_enter = word[9:5];
      2'd2:    dec_enter = word[14:10];
      default: dec_enter = word[19:15];
    endcase
    unique case (state)
      PLAY, CHECK: dec_show = mask[slot];
      DONE:        dec_show = lose | mask[slot];
      default:     dec_show = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hangman_display_ctrl.sv
module tb_hangman_display_ctrl;
  localparam int unsigned SCAN_DIV = 4;

  // Slot order slot3..slot0 in the concatenations.
  localparam logic [19:0] W1 = {5'd3, 5'd1, 5'd19, 5'd8};
  localparam logic [19:0] W2 = {5'd5, 5'd2, 5'd5, 5'd5};

  typedef struct {
    logic       hit;
    logic [2:0] miss;
    logic       win;
    logic       lose;
    logic       ready;
  } exp_t;

  logic       clock;
  logic       resetn;
  logic [4:0] dec_enter;
  logic       dec_show;
  logic [3:0] digit_sel;
  logic [2:0] miss_count;
  logic       hit, win, lose;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sbq[$];

  hangman_display_ctrl_if bus ();

  hangman_display_ctrl #(.SCAN_DIV(SCAN_DIV), .MAX_MISS(6)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .bus        (bus),
    .dec_enter  (dec_enter),
    .dec_show   (dec_show),
    .digit_sel  (digit_sel),
    .miss_count (miss_count),
    .hit        (hit),
    .win        (win),
    .lose       (lose)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic [2:0] m, input logic w,
                              input logic l, input logic r);
    exp_t e;
    e.hit = h; e.miss = m; e.win = w; e.lose = l; e.ready = r;
    return e;
  endfunction

  // Monitor: an accepted guess (seen at a falling edge) yields its result
  // two falling edges later; compare that cycle against the queue head.
  initial begin
    logic [1:0] due;
    exp_t e;
    due = 2'b00;
    forever begin
      @(negedge clock);
      if (due[1]) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_unexpected: response with empty queue");
        end else begin
          e = sbq.pop_front();
          chk("resp_hit",   {31'd0, hit},        {31'd0, e.hit});
          chk("resp_miss",  {29'd0, miss_count}, {29'd0, e.miss});
          chk("resp_win",   {31'd0, win},        {31'd0, e.win});
          chk("resp_lose",  {31'd0, lose},       {31'd0, e.lose});
          chk("resp_ready", {31'd0, bus.guess_ready}, {31'd0, e.ready});
        end
      end else begin
        chk("hit_idle", {31'd0, hit}, 32'd0);
      end
      due = {due[0], bus.guess_valid && bus.guess_ready};
    end
  end

  task automatic do_load(input logic [19:0] w);
    @(posedge clock); #1;
    bus.load = 1'b1; bus.word_in = w;
    @(posedge clock); #1;
    bus.load = 1'b0;
  endtask

  task automatic do_guess(input logic [4:0] code, input exp_t e);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clock); #1;
      if (bus.guess_ready) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL guess_ready_timeout: got 0 expected 1");
    end else begin
      bus.guess_valid = 1'b1;
      bus.guess_code  = code;
      sbq.push_back(e);
      @(posedge clock); #1;
      bus.guess_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clock);
    if (sbq.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL sb_timeout: %0d pending expected 0", sbq.size());
    end
  endtask

  task automatic check_scan(input logic [19:0] w, input logic [3:0] show);
    int s;
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clock);
      s = -1;
      case (digit_sel)
        4'b0001: s = 0;
        4'b0010: s = 1;
        4'b0100: s = 2;
        4'b1000: s = 3;
        default: s = -1;
      endcase
      if (s < 0) begin
        chk("digit_sel_onehot", {28'd0, digit_sel}, 32'd1);
      end else begin
        chk("scan_enter", {27'd0, dec_enter}, {27'd0, w[s*5 +: 5]});
        chk("scan_show",  {31'd0, dec_show},  {31'd0, show[s]});
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_digit_sel"}, {28'd0, digit_sel},  32'h1);
    chk({tag, "_dec_enter"}, {27'd0, dec_enter},  32'h0);
    chk({tag, "_dec_show"},  {31'd0, dec_show},   32'h0);
    chk({tag, "_miss"},      {29'd0, miss_count}, 32'h0);
    chk({tag, "_hit"},       {31'd0, hit},        32'h0);
    chk({tag, "_win"},       {31'd0, win},        32'h0);
    chk({tag, "_lose"},      {31'd0, lose},       32'h0);
    chk({tag, "_ready"},     {31'd0, bus.guess_ready}, 32'h0);
  endtask

  initial begin
    logic [3:0] exp_sel;
    resetn          = 1'b0;
    bus.load        = 1'b0;
    bus.word_in     = '0;
    bus.guess_valid = 1'b0;
    bus.guess_code  = '0;

    #12;
    check_reset_vals("rst");
    @(posedge clock); #1;
    resetn = 1'b1;

    // Each slot held SCAN_DIV cycles, then wraps.
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      exp_sel = 4'b0001 << ((k / SCAN_DIV) % 4);
      chk("scan_seq", {28'd0, digit_sel}, {28'd0, exp_sel});
    end

    // Win: every guess hits, win on the last.
    do_load(W1);
    do_guess(5'd19, mk(1, 0, 0, 0, 1));
    do_guess(5'd3,  mk(1, 0, 0, 0, 1));
    do_guess(5'd1,  mk(1, 0, 0, 0, 1));
    do_guess(5'd8,  mk(1, 0, 1, 0, 0));
    wait_drain();
    check_scan(W1, 4'b1111);

    // Lose: six misses, word revealed in DONE.
    do_load(W1);
    for (int i = 1; i <= 6; i++)
      do_guess(5'd31, mk(0, 3'(i), 0, (i == 6), (i < 6)));
    wait_drain();
    check_scan(W1, 4'b1111);

    // Repeated letter reveals three slots at once; repeat guess is a free hit.
    do_load(W2);
    do_guess(5'd5, mk(1, 0, 0, 0, 1));
    wait_drain();
    check_scan(W2, 4'b1011);
    do_guess(5'd5,  mk(1, 0, 0, 0, 1));
    do_guess(5'd31, mk(0, 1, 0, 0, 1));
    wait_drain();
    check_scan(W2, 4'b1011);

    // Load together with a guess: guess dropped, game restarted.
    @(posedge clock); #1;
    bus.load = 1'b1; bus.word_in = W1;
    bus.guess_valid = 1'b1; bus.guess_code = 5'd8;
    #1;
    chk("ready_during_load", {31'd0, bus.guess_ready}, 32'd0);
    @(posedge clock); #1;
    bus.load = 1'b0; bus.guess_valid = 1'b0;
    check_scan(W1, 4'b0000);
    chk("miss_after_load", {29'd0, miss_count}, 32'd0);

    // Reset during CHECK: response cycle must show idle/reset values.
    do_guess(5'd8, mk(0, 0, 0, 0, 0));
    #1 resetn = 1'b0;
    #1 check_reset_vals("async_rst");
    #1 resetn = 1'b1;
    wait_drain();
    check_scan(20'd0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
